// File: rtl/trap_seq.sv
// trap_seq: SPARC V8 integer-unit trap sequencer.
// Samples pending synchronous exceptions, Ticc software traps and (optionally)
// external interrupts while idle and picks the highest-priority one. It then
// walks a fixed sequence: flush, TBR write plus PSR side effects, PC save,
// and vector hand-off to fetch over a valid/ready handshake.
// An enabled trap with ET=0 from an exception or Ticc drops into error mode.
// Build option: define TRAP_SEQ_INTR_EN to include interrupt qualification
// (tt 0x11-0x1F). Without it, irl/psr_pil are ignored and no interrupt logic exists.
module trap_seq (
   input  logic        Clk,
   input  logic        Clr,
   input  logic [6:0]  exc_req,
   input  logic        ticc_req,
   input  logic [6:0]  ticc_tn,
   input  logic [3:0]  irl,
   input  logic        psr_et,
   input  logic [3:0]  psr_pil,
   input  logic [31:0] tbr_q,
   input  logic        vec_ready,
   output logic [19:0] tbr_tba,
   output logic [7:0]  tbr_tt,
   output logic        tbr_we,
   output logic        et_clr,
   output logic        s_set,
   output logic        cwp_dec,
   output logic        save_pc,
   output logic        flush,
   output logic        vec_valid,
   output logic [31:0] trap_vec,
   output logic        busy,
   output logic        error_mode
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TAKE  = 3'd1,
      ST_WRTBR = 3'd2,
      ST_SAVE  = 3'd3,
      ST_VEC   = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  tt_q, tt_d;
   logic        flush_q, flush_d;
   logic        wrtbr_q, wrtbr_d;
   logic        save_q, save_d;
   logic        vec_q, vec_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic        sync_req_s;
   logic        intr_req_s;
   logic        any_req_s;
   logic [7:0]  req_tt_s;

   // Trap type of the highest-priority pending synchronous exception.
   function automatic logic [7:0] exc_tt(input logic [6:0] e);
      logic [7:0] tt;
      if (e[0])      tt = 8'h01;
      else if (e[1]) tt = 8'h03;
      else if (e[2]) tt = 8'h02;
      else if (e[3]) tt = 8'h05;
      else if (e[4]) tt = 8'h06;
      else if (e[5]) tt = 8'h07;
      else if (e[6]) tt = 8'h2A;
      else           tt = 8'h00;
      return tt;
   endfunction

   // The low TBR nibble never reaches the vector; it is zero by construction.
   logic unused_tbr_s;
   assign unused_tbr_s = ^tbr_q[3:0];

`ifdef TRAP_SEQ_INTR_EN
   // Interrupt qualifies above PIL (level 15 is non-maskable) with traps enabled.
   always_comb begin
      intr_req_s = 1'b0;
      if (psr_et && (irl != 4'd0) && ((irl > psr_pil) || (irl == 4'd15))) begin
         intr_req_s = 1'b1;
      end else begin
         intr_req_s = 1'b0;
      end
   end
`else
   assign intr_req_s = 1'b0;
   logic unused_intr_s;
   assign unused_intr_s = ^{irl, psr_pil};
`endif

   // Priority selection: exceptions, then Ticc, then interrupts.
   always_comb begin
      sync_req_s = (|exc_req) | ticc_req;
      any_req_s  = sync_req_s | intr_req_s;
      req_tt_s   = 8'h00;
      if (|exc_req) begin
         req_tt_s = exc_tt(exc_req);
      end else if (ticc_req) begin
         req_tt_s = {1'b1, ticc_tn};
`ifdef TRAP_SEQ_INTR_EN
      end else if (intr_req_s) begin
         req_tt_s = {4'h1, irl};
`endif
      end else begin
         req_tt_s = 8'h00;
      end
   end

   // Next-state logic and registered-output decode of the next state.
   always_comb begin
      state_d = state_q;
      tt_d    = tt_q;
      case (state_q)
         ST_IDLE: begin
            if (psr_et && any_req_s) begin
               state_d = ST_TAKE;
               tt_d    = req_tt_s;
            end else if (!psr_et && sync_req_s) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TAKE:  state_d = ST_WRTBR;
         ST_WRTBR: state_d = ST_SAVE;
         ST_SAVE:  state_d = ST_VEC;
         ST_VEC: begin
            if (vec_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_VEC;
            end
         end
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase
      flush_d = (state_d == ST_TAKE);
      wrtbr_d = (state_d == ST_WRTBR);
      save_d  = (state_d == ST_SAVE);
      vec_d   = (state_d == ST_VEC);
      busy_d  = (state_d != ST_IDLE);
      err_d   = (state_d == ST_ERROR);
   end

   // State, trap type and output registers; Clr abandons any sequence at once.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= ST_IDLE;
         tt_q    <= 8'h00;
         flush_q <= 1'b0;
         wrtbr_q <= 1'b0;
         save_q  <= 1'b0;
         vec_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tt_q    <= tt_d;
         flush_q <= flush_d;
         wrtbr_q <= wrtbr_d;
         save_q  <= save_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign tbr_tba    = tbr_q[31:12];
   assign tbr_tt     = tt_q;
   assign tbr_we     = wrtbr_q;
   assign et_clr     = wrtbr_q;
   assign s_set      = wrtbr_q;
   assign cwp_dec    = wrtbr_q;
   assign save_pc    = save_q;
   assign flush      = flush_q;
   assign vec_valid  = vec_q;
   assign trap_vec   = vec_q ? {tbr_q[31:4], 4'b0000} : 32'h0000_0000;
   assign busy       = busy_q;
   assign error_mode = err_q;

endmodule

// File: tb/tb_trap_seq.sv
// Self-checking bench for trap_seq: directed cases from the trap rules plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_trap_seq;

   logic        Clk = 1'b0;
   logic        Clr = 1'b0;
   logic [6:0]  exc_req = 7'd0;
   logic        ticc_req = 1'b0;
   logic [6:0]  ticc_tn = 7'd0;
   logic [3:0]  irl = 4'd0;
   logic        psr_et = 1'b1;
   logic [3:0]  psr_pil = 4'd0;
   logic [31:0] tbr_q = 32'h4000_0000;
   logic        vec_ready = 1'b0;
   logic [19:0] tbr_tba;
   logic [7:0]  tbr_tt;
   logic        tbr_we, et_clr, s_set, cwp_dec, save_pc, flush, vec_valid, busy, error_mode;
   logic [31:0] trap_vec;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: cycles elapsed since a trap was accepted (0 = idle), error flag, last tt.
   int         m_pos = 0;
   bit         m_err = 1'b0;
   logic [7:0] m_tt  = 8'h00;
   logic [7:0] tt_tab [0:6] = '{8'h01, 8'h03, 8'h02, 8'h05, 8'h06, 8'h07, 8'h2A};

   trap_seq dut (
      .Clk(Clk), .Clr(Clr), .exc_req(exc_req), .ticc_req(ticc_req), .ticc_tn(ticc_tn),
      .irl(irl), .psr_et(psr_et), .psr_pil(psr_pil), .tbr_q(tbr_q), .vec_ready(vec_ready),
      .tbr_tba(tbr_tba), .tbr_tt(tbr_tt), .tbr_we(tbr_we), .et_clr(et_clr), .s_set(s_set),
      .cwp_dec(cwp_dec), .save_pc(save_pc), .flush(flush), .vec_valid(vec_valid),
      .trap_vec(trap_vec), .busy(busy), .error_mode(error_mode)
   );

   always #5 Clk = ~Clk;

   function automatic bit model_intr();
`ifdef TRAP_SEQ_INTR_EN
      return psr_et && (irl != 4'd0) && ((irl > psr_pil) || (irl == 4'd15));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] model_tt();
      for (int i = 0; i < 7; i++) begin
         if (exc_req[i]) return tt_tab[i];
      end
      if (ticc_req) return {1'b1, ticc_tn};
      return {4'h1, irl};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit live;
      live = !m_err;
      check("tbr_tba",    32'(tbr_tba),    32'(tbr_q[31:12]));
      check("tbr_tt",     32'(tbr_tt),     32'(m_tt));
      check("tbr_we",     32'(tbr_we),     32'(live && m_pos == 2));
      check("et_clr",     32'(et_clr),     32'(live && m_pos == 2));
      check("s_set",      32'(s_set),      32'(live && m_pos == 2));
      check("cwp_dec",    32'(cwp_dec),    32'(live && m_pos == 2));
      check("save_pc",    32'(save_pc),    32'(live && m_pos == 3));
      check("flush",      32'(flush),      32'(live && m_pos == 1));
      check("vec_valid",  32'(vec_valid),  32'(live && m_pos == 4));
      check("trap_vec",   trap_vec, (live && m_pos == 4) ? {tbr_q[31:4], 4'h0} : 32'h0);
      check("busy",       32'(busy),       32'(m_err || m_pos != 0));
      check("error_mode", 32'(error_mode), 32'(m_err));
   endtask

   // Advance one clock: model reacts at the rising edge, outputs checked at the falling edge.
   task automatic step();
      bit wr;
      bit req_sync;
      bit req_any;
      @(posedge Clk);
      wr = 1'b0;
      if (!Clr) begin
         m_pos = 0; m_err = 1'b0; m_tt = 8'h00;
      end else if (m_err) begin
         m_err = 1'b1;
      end else if (m_pos == 0) begin
         req_sync = (exc_req != 7'd0) || ticc_req;
         req_any  = req_sync || model_intr();
         if (psr_et && req_any) begin
            m_pos = 1;
            m_tt  = model_tt();
         end else if (!psr_et && req_sync) begin
            m_err = 1'b1;
         end
      end else if (m_pos < 4) begin
         wr = (m_pos == 2);
         m_pos++;
      end else if (vec_ready) begin
         m_pos = 0;
      end
      #1;
      if (wr) tbr_q = {tbr_q[31:12], m_tt, 4'h0};
      @(negedge Clk);
      compare_all();
   endtask

   task automatic assert_clr();
      Clr = 1'b0;
      m_pos = 0; m_err = 1'b0; m_tt = 8'h00;
      #1;
      compare_all();
   endtask

   task automatic clear_reqs();
      exc_req = 7'd0; ticc_req = 1'b0; ticc_tn = 7'd0; irl = 4'd0; psr_pil = 4'd0;
   endtask

   // Present the current requests for one edge, check the latched tt, then finish the trap.
   task automatic take_check(input string name, input logic [7:0] exp_tt);
      step();
      check(name, 32'(tbr_tt), 32'(exp_tt));
      check({name, "_busy"}, 32'(busy), 32'd1);
      clear_reqs();
      vec_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      vec_ready = 1'b0;
      check({name, "_done"}, 32'(busy), 32'd0);
   endtask

   task automatic no_trap_check(input string name);
      step();
      check(name, 32'(busy), 32'd0);
      clear_reqs();
      step();
   endtask

   initial begin
      // Reset
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tt", 32'(tbr_tt), 32'd0);
      check("rst_tba", 32'(tbr_tba), 32'h40000);
      Clr = 1'b1;
      step();

      // Single exception, full timeline and literal vector
      psr_et = 1'b1;
      exc_req = 7'b0000100;
      step();
      exc_req = 7'd0;
      check("single_flush", 32'(flush), 32'd1);
      step();
      check("single_we", 32'(tbr_we), 32'd1);
      check("single_tt", 32'(tbr_tt), 32'h02);
      check("single_tba", 32'(tbr_tba), 32'h40000);
      step();
      check("single_save", 32'(save_pc), 32'd1);
      step();
      check("single_valid", 32'(vec_valid), 32'd1);
      check("single_vec", trap_vec, 32'h4000_0020);

      // Handshake stall; new exception during VEC ignored
      exc_req = 7'b0000001;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", 32'(vec_valid), 32'd1);
         check("stall_vec", trap_vec, 32'h4000_0020);
      end
      exc_req = 7'd0;
      vec_ready = 1'b1;
      step();
      vec_ready = 1'b0;
      check("hs_idle", 32'(busy), 32'd0);
      check("hs_tt_kept", 32'(tbr_tt), 32'h02);

      // Priority
      tbr_q = 32'h4000_0000;
      exc_req = 7'b1001000; ticc_req = 1'b1; ticc_tn = 7'h11; irl = 4'd5;
      take_check("prio_exc", 8'h05);
      ticc_req = 1'b1; ticc_tn = 7'h03;
      take_check("prio_ticc", 8'h83);

      // Interrupt masking
`ifdef TRAP_SEQ_INTR_EN
      psr_pil = 4'd7; irl = 4'd5;
      no_trap_check("intr_masked");
      psr_pil = 4'd7; irl = 4'd9;
      take_check("intr_9", 8'h19);
      psr_pil = 4'd15; irl = 4'd15;
      take_check("intr_15", 8'h1F);
`else
      psr_pil = 4'd0; irl = 4'd15;
      no_trap_check("intr_disabled");
`endif

      // ET=0 -> error mode, absorbing until Clr
      psr_et = 1'b0;
      exc_req = 7'b0100000;
      step();
      exc_req = 7'd0;
      check("et0_err", 32'(error_mode), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("et0_no_we", 32'(tbr_we), 32'd0);
         check("et0_stay", 32'(error_mode), 32'd1);
      end
      psr_et = 1'b1;
      assert_clr();
      check("et0_clr_err", 32'(error_mode), 32'd0);
      check("et0_clr_busy", 32'(busy), 32'd0);
      step();
      Clr = 1'b1;
      step();

      // Reset during WRTBR
      exc_req = 7'b0000010;
      step();
      exc_req = 7'd0;
      step();
      check("mid_we", 32'(tbr_we), 32'd1);
      assert_clr();
      check("mid_we_clr", 32'(tbr_we), 32'd0);
      check("mid_busy_clr", 32'(busy), 32'd0);
      step();
      Clr = 1'b1;
      step();
      check("mid_no_save", 32'(save_pc), 32'd0);
      step();
      check("mid_idle", 32'(busy), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         exc_req   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0;
         ticc_req  = ($urandom_range(0, 9) == 0);
         ticc_tn   = 7'($urandom);
         irl       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
         psr_pil   = 4'($urandom);
         psr_et    = ($urandom_range(0, 49) != 0);
         vec_ready = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) tbr_q = $urandom;
         if (m_err || $urandom_range(0, 399) == 0) begin
            assert_clr();
            step();
            Clr = 1'b1;
         end else begin
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
